// File: rtl/uart_pkg.sv
// Shared types, line levels and the parity helper for the UART transmitter and receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Takes the XOR of the payload so the helper stays independent of the data width.
   function automatic logic parity_bit(input logic data_xor, input logic parity_type);
      return (parity_type == PARITY_ODD) ? ~data_xor : data_xor;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: synchronises the line, votes each bit mid-period and reports good frames or errors as strobes.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      parity_enable,
   input  logic                      parity_type,
   input  logic                      serial,
   output logic [DATA_WIDTH-1:0]     data,
   output logic                      valid,
   output logic                      par_err,
   output logic                      stp_err
);

   localparam int IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

   uart_state_t               state, state_n;
   logic [PRESCALE_WIDTH-1:0] cnt, cnt_n;
   logic [IDX_WIDTH-1:0]      bit_idx, idx_n;
   logic [DATA_WIDTH-1:0]     shreg, shreg_n;
   logic [DATA_WIDTH-1:0]     data_n;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_n;
   logic [PRESCALE_WIDTH-1:0] half;
   logic                      par_en_q, par_en_n;
   logic                      par_type_q, par_type_n;
   logic                      par_bad, par_bad_n;
   logic                      valid_n, par_err_n, stp_err_n;
   logic                      sync_meta, rx_line;
   logic                      sample, decide, bit_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b1;
         rx_line   <= 1'b1;
      end else begin
         sync_meta <= serial;
         rx_line   <= sync_meta;
      end
   end

   assign half = prescale_q >> 1;

   uart_rx_sampler #(
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_sampler (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_line  (rx_line),
      .cnt      (cnt),
      .half     (half),
      .bit_value(sample),
      .decide   (decide)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         prescale_q <= '0;
         par_en_q   <= 1'b0;
         par_type_q <= PARITY_EVEN;
         par_bad    <= 1'b0;
         data       <= '0;
         valid      <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_idx    <= idx_n;
         shreg      <= shreg_n;
         prescale_q <= prescale_n;
         par_en_q   <= par_en_n;
         par_type_q <= par_type_n;
         par_bad    <= par_bad_n;
         data       <= data_n;
         valid      <= valid_n;
         par_err    <= par_err_n;
         stp_err    <= stp_err_n;
      end
   end

   // The stop decision returns straight to IDLE so a back-to-back start edge is not missed.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      idx_n      = bit_idx;
      shreg_n    = shreg;
      prescale_n = prescale_q;
      par_en_n   = par_en_q;
      par_type_n = par_type_q;
      par_bad_n  = par_bad;
      data_n     = data;
      valid_n    = 1'b0;
      par_err_n  = 1'b0;
      stp_err_n  = 1'b0;
      bit_end    = (cnt == prescale_q - 1'b1);

      if (state != IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;

      case (state)
         IDLE: begin
            if (rx_line == START_BIT) begin
               state_n    = START;
               cnt_n      = '0;
               prescale_n = prescale;
               par_en_n   = parity_enable;
               par_type_n = parity_type;
               par_bad_n  = 1'b0;
            end
         end
         START: begin
            if (decide && sample == STOP_BIT) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (bit_end) begin
               state_n = DATA;
               idx_n   = '0;
            end
         end
         DATA: begin
            if (decide) shreg_n = {sample, shreg[DATA_WIDTH-1:1]};
            if (bit_end) begin
               if (bit_idx == LAST_IDX) state_n = par_en_q ? PARITY : STOP;
               else idx_n = bit_idx + 1'b1;
            end
         end
         PARITY: begin
            if (decide) par_bad_n = (sample != parity_bit(^shreg, par_type_q));
            if (bit_end) state_n = STOP;
         end
         STOP: begin
            if (decide) begin
               state_n   = IDLE;
               cnt_n     = '0;
               par_err_n = par_bad;
               stp_err_n = (sample != STOP_BIT);
               if (sample == STOP_BIT && !par_bad) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: rtl/uart_rx_sampler.sv
// Three-point majority vote around the middle of a bit; the third vote is the live line at the decision count.
module uart_rx_sampler #(
   parameter int PRESCALE_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx_line,
   input  logic [PRESCALE_WIDTH-1:0] cnt,
   input  logic [PRESCALE_WIDTH-1:0] half,
   output logic                      bit_value,
   output logic                      decide
);

   logic early, mid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         early <= 1'b1;
         mid   <= 1'b1;
      end else begin
         if (cnt == half - 1'b1) early <= rx_line;
         if (cnt == half) mid <= rx_line;
      end
   end

   assign decide    = (cnt == half + 1'b1);
   assign bit_value = (early & mid) | (early & rx_line) | (mid & rx_line);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: latches a byte and its framing settings, then shifts the frame out LSB first.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      parity_enable,
   input  logic                      parity_type,
   input  logic [DATA_WIDTH-1:0]     data,
   input  logic                      valid,
   output logic                      serial,
   output logic                      busy
);

   localparam int IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

   uart_state_t               state, state_n;
   logic [PRESCALE_WIDTH-1:0] cnt, cnt_n;
   logic [IDX_WIDTH-1:0]      bit_idx, idx_n;
   logic [DATA_WIDTH-1:0]     data_q, data_n;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_n;
   logic                      par_en_q, par_en_n;
   logic                      par_type_q, par_type_n;
   logic                      serial_n;
   logic                      bit_end;
   logic                      accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         data_q     <= '0;
         prescale_q <= '0;
         par_en_q   <= 1'b0;
         par_type_q <= PARITY_EVEN;
         serial     <= STOP_BIT;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_idx    <= idx_n;
         data_q     <= data_n;
         prescale_q <= prescale_n;
         par_en_q   <= par_en_n;
         par_type_q <= par_type_n;
         serial     <= serial_n;
         busy       <= (state_n != IDLE);
      end
   end

   // The line level is derived from the next state so the serial output comes straight from a flop.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      idx_n      = bit_idx;
      data_n     = data_q;
      prescale_n = prescale_q;
      par_en_n   = par_en_q;
      par_type_n = par_type_q;
      accept     = 1'b0;
      bit_end    = (cnt == prescale_q - 1'b1);

      case (state)
         IDLE: begin
            if (valid) accept = 1'b1;
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               cnt_n   = '0;
               idx_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_n = '0;
               if (bit_idx == LAST_IDX) state_n = par_en_q ? PARITY : STOP;
               else idx_n = bit_idx + 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_n = STOP;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (valid) begin
                  accept = 1'b1;
               end else begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase

      if (accept) begin
         state_n    = START;
         cnt_n      = '0;
         idx_n      = '0;
         data_n     = data;
         prescale_n = prescale;
         par_en_n   = parity_enable;
         par_type_n = parity_type;
      end

      case (state_n)
         START:   serial_n = START_BIT;
         DATA:    serial_n = data_n[idx_n];
         PARITY:  serial_n = parity_bit(^data_n, par_type_n);
         default: serial_n = STOP_BIT;
      endcase
   end

endmodule

// File: rtl/uart_top.sv
// Full-duplex UART endpoint: independent transmitter and receiver sharing one oversampling clock.
module uart_top
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 5
) (
   input  logic                      UART_CLK,
   input  logic                      RST,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   input  logic                      parity_enable,
   input  logic                      parity_type,
   input  logic [DATA_WIDTH-1:0]     TX_IN_P,
   input  logic                      TX_IN_V,
   output logic                      TX_OUT_S,
   output logic                      TX_OUT_Busy,
   input  logic                      RX_IN_S,
   output logic [DATA_WIDTH-1:0]     RX_OUT_P,
   output logic                      RX_OUT_V,
   output logic                      PAR_ERR,
   output logic                      STP_ERR
);

   uart_tx #(
      .DATA_WIDTH    (DATA_WIDTH),
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_tx (
      .clk          (UART_CLK),
      .rst_n        (RST),
      .prescale     (Prescale),
      .parity_enable(parity_enable),
      .parity_type  (parity_type),
      .data         (TX_IN_P),
      .valid        (TX_IN_V),
      .serial       (TX_OUT_S),
      .busy         (TX_OUT_Busy)
   );

   uart_rx #(
      .DATA_WIDTH    (DATA_WIDTH),
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_rx (
      .clk          (UART_CLK),
      .rst_n        (RST),
      .prescale     (Prescale),
      .parity_enable(parity_enable),
      .parity_type  (parity_type),
      .serial       (RX_IN_S),
      .data         (RX_OUT_P),
      .valid        (RX_OUT_V),
      .par_err      (PAR_ERR),
      .stp_err      (STP_ERR)
   );

endmodule

// File: tb/tb_uart_top.sv
// Randomised bench for uart_top: frames are built and decoded by a bit-list reference model.
`timescale 1ns/1ps
module tb_uart_top;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] prescale;
   logic       pen, ptype;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_serial, tx_busy;
   logic       rx_drive, loopback, rx_line;
   logic [7:0] rx_data;
   logic       rx_valid, par_err, stp_err;

   int         checks = 0;
   int         errors = 0;
   int         valid_cnt = 0, par_cnt = 0, stp_cnt = 0;
   logic [7:0] rx_log[$];
   logic [7:0] last_good;

   always #5 clk = ~clk;

   assign rx_line = loopback ? tx_serial : rx_drive;

   uart_top dut (
      .UART_CLK     (clk),
      .RST          (rst_n),
      .Prescale     (prescale),
      .parity_enable(pen),
      .parity_type  (ptype),
      .TX_IN_P      (tx_data),
      .TX_IN_V      (tx_valid),
      .TX_OUT_S     (tx_serial),
      .TX_OUT_Busy  (tx_busy),
      .RX_IN_S      (rx_line),
      .RX_OUT_P     (rx_data),
      .RX_OUT_V     (rx_valid),
      .PAR_ERR      (par_err),
      .STP_ERR      (stp_err)
   );

   // Every high cycle of a strobe is counted, so an over-wide pulse shows up as an extra event.
   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt++;
         rx_log.push_back(rx_data);
      end
      if (par_err) par_cnt++;
      if (stp_err) stp_cnt++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic void buildFrame(input logic [7:0] d, input bit pe, input bit pt,
                                      output logic [10:0] f, output int len);
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
      if (pe) begin
         f[9] = 1'(($countones(d) + pt) % 2);
         len = 11;
      end else begin
         len = 10;
      end
   endfunction

   function automatic void decodeFrame(input logic [10:0] f, input int len, input bit pe, input bit pt,
                                       output logic [7:0] d, output bit perr, output bit serr);
      for (int i = 0; i < 8; i++) d[i] = f[i+1];
      perr = pe && ((($countones(d) + f[9]) % 2) != pt);
      serr = (f[len-1] == 1'b0);
   endfunction

   task automatic applyStimulus(input logic [7:0] d, input int p, input bit pe, input bit pt, input bit hold);
      @(negedge clk);
      prescale = 5'(p);
      pen      = pe;
      ptype    = pt;
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) tx_valid = 1'b0;
   endtask

   task automatic captureFrame(input logic [10:0] f, input int len, input int p);
      int busy_cycles;
      int match;
      busy_cycles = 0;
      for (int b = 0; b < len; b++) begin
         match = 0;
         for (int c = 0; c < p; c++) begin
            @(negedge clk);
            if (tx_serial === f[b]) match++;
            if (tx_busy === 1'b1) busy_cycles++;
         end
         checkOutput($sformatf("tx_bit%0d", b), match, p);
      end
      checkOutput("tx_busy_cycles", busy_cycles, len * p);
   endtask

   task automatic checkRx(input string tag, input int v0, input int p0, input int s0,
                          input logic [10:0] f, input int len, input bit pe, input bit pt);
      logic [7:0] d;
      bit perr, serr, good;
      decodeFrame(f, len, pe, pt, d, perr, serr);
      good = !perr && !serr;
      checkOutput({tag, "_valid"}, valid_cnt - v0, good);
      checkOutput({tag, "_par"}, par_cnt - p0, perr);
      checkOutput({tag, "_stp"}, stp_cnt - s0, serr);
      if (good) last_good = d;
      checkOutput({tag, "_data"}, rx_data, last_good);
   endtask

   task automatic runTxFrame(input logic [7:0] d, input int p, input bit pe, input bit pt, input string tag);
      logic [10:0] f;
      int len, v0, p0, s0;
      buildFrame(d, pe, pt, f, len);
      v0 = valid_cnt;
      p0 = par_cnt;
      s0 = stp_cnt;
      applyStimulus(d, p, pe, pt, 1'b0);
      captureFrame(f, len, p);
      @(negedge clk);
      checkOutput({tag, "_busy_fall"}, tx_busy, 1'b0);
      repeat (2 * p + 4) @(negedge clk);
      checkRx(tag, v0, p0, s0, f, len, pe, pt);
   endtask

   task automatic runRxFrame(input logic [10:0] f, input int len, input int p, input bit pe, input bit pt,
                             input string tag);
      int v0, p0, s0;
      @(negedge clk);
      prescale = 5'(p);
      pen      = pe;
      ptype    = pt;
      v0 = valid_cnt;
      p0 = par_cnt;
      s0 = stp_cnt;
      for (int b = 0; b < len; b++) begin
         rx_drive = f[b];
         repeat (p) @(negedge clk);
      end
      rx_drive = 1'b1;
      repeat (2 * p + 8) @(negedge clk);
      checkRx(tag, v0, p0, s0, f, len, pe, pt);
   endtask

   initial begin
      logic [10:0] f, f2;
      int len, len2, p, v0, p0, s0, n0;
      logic [7:0] d;
      bit pe, pt;

      rst_n     = 1'b1;
      prescale  = 5'd8;
      pen       = 1'b1;
      ptype     = 1'b0;
      tx_data   = 8'h00;
      tx_valid  = 1'b0;
      rx_drive  = 1'b1;
      loopback  = 1'b1;
      last_good = 8'h00;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_tx_s", tx_serial, 1'b1);
      checkOutput("rst_busy", tx_busy, 1'b0);
      checkOutput("rst_rx_v", rx_valid, 1'b0);
      checkOutput("rst_par", par_err, 1'b0);
      checkOutput("rst_stp", stp_err, 1'b0);
      checkOutput("rst_rx_p", rx_data, 8'h00);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] loopback and TX waveform frames");
      runTxFrame(8'hBB, 8, 1'b1, 1'b0, "loop_bb");
      runTxFrame(8'h43, 8, 1'b1, 1'b0, "wave43_even");
      runTxFrame(8'h43, 8, 1'b1, 1'b1, "wave43_odd");
      for (int i = 0; i < 8; i++) begin
         d  = 8'($urandom_range(0, 255));
         p  = $urandom_range(6, 31);
         pe = 1'($urandom_range(0, 1));
         pt = 1'($urandom_range(0, 1));
         runTxFrame(d, p, pe, pt, $sformatf("rand_loop%0d", i));
      end

      $display("[TB] back-to-back frames at P=16");
      buildFrame(8'h2A, 1'b0, 1'b0, f, len);
      buildFrame(8'h0E, 1'b0, 1'b0, f2, len2);
      v0 = valid_cnt;
      n0 = rx_log.size();
      applyStimulus(8'h2A, 16, 1'b0, 1'b0, 1'b1);
      fork
         begin
            tx_data = 8'h0E;
            repeat (160) @(posedge clk);
            #1 tx_valid = 1'b0;
         end
         begin
            captureFrame(f, len, 16);
            captureFrame(f2, len2, 16);
         end
      join
      @(negedge clk);
      checkOutput("b2b_busy_fall", tx_busy, 1'b0);
      repeat (40) @(negedge clk);
      checkOutput("b2b_count", valid_cnt - v0, 2);
      if (rx_log.size() >= n0 + 2) begin
         checkOutput("b2b_first", rx_log[n0], 8'h2A);
         checkOutput("b2b_second", rx_log[n0+1], 8'h0E);
      end
      last_good = 8'h0E;

      $display("[TB] error injection on the receive line");
      loopback = 1'b0;
      buildFrame(8'h2A, 1'b1, 1'b0, f, len);
      f[9] = ~f[9];
      runRxFrame(f, len, 8, 1'b1, 1'b0, "inj_par");
      buildFrame(8'h2A, 1'b1, 1'b0, f, len);
      f[10] = 1'b0;
      runRxFrame(f, len, 8, 1'b1, 1'b0, "inj_stp");
      for (int i = 0; i < 8; i++) begin
         d  = 8'($urandom_range(0, 255));
         p  = $urandom_range(6, 31);
         pe = 1'($urandom_range(0, 1));
         pt = 1'($urandom_range(0, 1));
         buildFrame(d, pe, pt, f, len);
         if (pe && $urandom_range(0, 1) == 1) f[9] = ~f[9];
         if ($urandom_range(0, 2) == 0) f[len-1] = 1'b0;
         runRxFrame(f, len, p, pe, pt, $sformatf("rand_inj%0d", i));
      end

      $display("[TB] start-bit glitch");
      @(negedge clk);
      prescale = 5'd8;
      pen      = 1'b0;
      ptype    = 1'b0;
      v0 = valid_cnt;
      p0 = par_cnt;
      s0 = stp_cnt;
      rx_drive = 1'b0;
      repeat (2) @(negedge clk);
      rx_drive = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("glitch_valid", valid_cnt - v0, 0);
      checkOutput("glitch_par", par_cnt - p0, 0);
      checkOutput("glitch_stp", stp_cnt - s0, 0);
      buildFrame(8'h15, 1'b0, 1'b0, f, len);
      runRxFrame(f, len, 8, 1'b0, 1'b0, "after_glitch");

      $display("[TB] reset during transmission");
      loopback = 1'b1;
      v0 = valid_cnt;
      p0 = par_cnt;
      s0 = stp_cnt;
      applyStimulus(8'hFF, 8, 1'b1, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_tx_s", tx_serial, 1'b1);
      checkOutput("midrst_busy", tx_busy, 1'b0);
      checkOutput("midrst_rx_p", rx_data, 8'h00);
      last_good = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("midrst_valid", valid_cnt - v0, 0);
      checkOutput("midrst_par", par_cnt - p0, 0);
      checkOutput("midrst_stp", stp_cnt - s0, 0);
      runTxFrame(8'h01, 8, 1'b1, 1'b0, "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_top.md
# uart_top

Full-duplex serial UART endpoint clocked by one oversampling clock. It serialises bytes presented on a parallel valid interface and deserialises bytes arriving on the serial input. Parity is configurable, and the bit period equals `Prescale` clock cycles. It sits between the system's command/register logic and the serial pins, and is also used as the host-side model on system benches.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: payload bits per frame.
- `PRESCALE_WIDTH`, default 5: width of `Prescale`.

Ports:
- `UART_CLK`, in, 1: oversampling clock; every register is clocked on its rising edge.
- `RST`, in, 1: reset, asynchronous and active-low.
- `Prescale`, in, 5: clock cycles per bit. The legal range is 4..31; 8 and 16 are the nominal values.
- `parity_enable`, in, 1: 1 inserts a parity bit into transmitted frames and expects one in received frames.
- `parity_type`, in, 1: 0 selects even parity; 1 selects odd parity.
- `TX_IN_P`, in, 8: byte to transmit.
- `TX_IN_V`, in, 1: transmit request; sampled only while the transmitter is not busy.
- `TX_OUT_S`, out, 1: serial output; idles high.
- `TX_OUT_Busy`, out, 1: high while a frame is being transmitted.
- `RX_IN_S`, in, 1: serial input, asynchronous to `UART_CLK`.
- `RX_OUT_P`, out, 8: last correctly received byte.
- `RX_OUT_V`, out, 1: one-cycle strobe for each good received frame.
- `PAR_ERR`, out, 1: one-cycle strobe when a received frame has a parity mismatch.
- `STP_ERR`, out, 1: one-cycle strobe when a received frame has a low stop bit.

## Operation
Frame format, on the wire in this order:
- start bit, 0;
- 8 data bits, LSB first;
- parity bit, present only when `parity_enable` = 1; it makes the count of ones in data + parity even (`parity_type` = 0) or odd (`parity_type` = 1);
- stop bit, 1.

Each bit lasts exactly `Prescale` cycles.

Configuration latching:
- `Prescale`, `parity_enable` and `parity_type` are captured at the start of each frame, separately for TX and RX.
- Changes made mid-frame take effect from the next frame.

TX state machine: IDLE → START → DATA(8) → PARITY (skipped when disabled) → STOP → IDLE.
- In IDLE, a rising edge with `TX_IN_V` = 1 latches `TX_IN_P`. On the same edge the FSM enters START and drives `TX_OUT_S` low.
- `TX_IN_V` is ignored while busy; there is no queueing.
- `TX_OUT_Busy` is high in START through STOP.
- In the last STOP cycle, if `TX_IN_V` = 1, the next frame starts on the following edge. This gives back-to-back frames with no idle gap.

RX input synchronisation:
- `RX_IN_S` passes through a 2-flop synchroniser.
- Every later reference to the line means the synchronised value.

RX state machine: IDLE → START → DATA(8) → PARITY (skipped when disabled) → STOP → IDLE.
- IDLE: a low line enters START with the in-bit counter at 0.
- Bit decision: the bit value is the majority of 3 samples taken at counts P/2−1, P/2 and P/2+1, where P = `Prescale` and P/2 rounds down.
- START: if the decided value is 1, the event is a glitch. Return to IDLE with no strobe.
- DATA: decided bits shift in LSB first.
- PARITY: the decided bit is compared with the computed parity.
- STOP: at the decision point the result is reported. The receiver then returns to IDLE immediately so that the next start edge can be caught.

RX result reporting:
- Stop = 1 and parity OK: load `RX_OUT_P` and pulse `RX_OUT_V`.
- Parity mismatch: pulse `PAR_ERR`.
- Stop = 0: pulse `STP_ERR`.
- `PAR_ERR` and `STP_ERR` may pulse together.
- On any error, `RX_OUT_P` holds its previous value.

Other RX rules:
- `RX_OUT_P` holds its value until the next good frame.
- TX and RX are fully independent; simultaneous activity in both directions is required to work.

## Timing
- Reset values: `TX_OUT_S` = 1; `TX_OUT_Busy`, `RX_OUT_V`, `PAR_ERR`, `STP_ERR` = 0; `RX_OUT_P` = 0x00. Both FSMs are in IDLE and all counters are 0.
- Reset asserted mid-frame aborts the frame immediately. `TX_OUT_S` goes high and no strobe is emitted.
- TX frame length is (10 + `parity_enable`) × `Prescale` cycles.
- `TX_OUT_Busy` rises on the accept edge and falls on the edge after the last stop cycle.
- RX latency: the strobe occurs 2 (synchroniser) + (9 + `parity_enable`) × P + P/2 + 2 cycles after the line falls.
- Strobes are exactly 1 cycle wide.

## Structure
Shared package `uart_pkg` holds:
- the FSM state enum (IDLE, START, DATA, PARITY, STOP);
- parity type constants (EVEN = 0, ODD = 1);
- the start/stop bit level constants.

Sub-modules:
- `uart_tx` and `uart_rx` are natural sub-modules; the top only wires them.
- The majority-vote sampler `uart_rx_sampler` is the one natural sub-module inside `uart_rx`.
- A parity function belongs in `uart_pkg`.

## Test plan
- Loopback (`TX_OUT_S` → `RX_IN_S`), P = 8, even parity, send 0xBB → exactly one `RX_OUT_V` pulse with `RX_OUT_P` = 0xBB. `TX_OUT_Busy` is high for 88 cycles.
- TX waveform, P = 8: send 0x43 → line shows 0, 1,1,0,0,0,0,1,0, then the parity bit and 1. The parity bit is 1 with even parity and 0 with odd parity.
- Parity-error injection: drive a frame carrying 0x2A with a flipped parity bit → `PAR_ERR` pulse, no `RX_OUT_V`, `RX_OUT_P` unchanged. Repeat with stop bit = 0 → `STP_ERR` pulse.
- P = 16, parity disabled: back-to-back frames 0x2A, 0x0E with `TX_IN_V` held → two RX strobes in order. No idle gap on the line; each frame is 160 cycles.
- RX start glitch: line low for 2 cycles (P = 8) → no strobe, receiver back in IDLE. A following real frame carrying 0x15 is received correctly.
- Reset asserted mid-transmission of 0xFF → `TX_OUT_S` = 1 and `TX_OUT_Busy` = 0 immediately. After release, a new frame carrying 0x01 transmits correctly.
